// File: rtl/operand_stage_n.sv
// operand_stage_n: N-lane operand-fetch stage registering decode fields and source operand values
// Build option: define OPERAND_WB_BYPASS_EN to enable capture-time writeback bypass and hold-time snoop.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall_i, flush_i              per-lane hold / kill
//   dec_*_i                       decoded instruction fields per lane (rs1..rs3 order within a lane)
//   rf_raddr_o / rf_rdata_i       register file read addresses (= dec_rs_i) and combinational read data
//   wb_valid_i/wb_rd_i/wb_value_i writeback ports (highest index wins)
//   op_*_o                        registered operands and pass-through fields toward execute
module operand_stage_n #(
    parameter int LANES     = 2,
    parameter int XLEN      = 64,
    parameter int NUM_WB    = 2,
    parameter int SID_W     = 5,
    parameter int PAYLOAD_W = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES-1:0]             stall_i,
    input  logic [LANES-1:0]             flush_i,
    input  logic [LANES-1:0]             dec_valid_i,
    input  logic [3*LANES-1:0]           dec_rs_valid_i,
    input  logic [15*LANES-1:0]          dec_rs_i,
    input  logic [PAYLOAD_W*LANES-1:0]   dec_payload_i,
    input  logic [SID_W*LANES-1:0]       dec_sid_i,
    output logic [15*LANES-1:0]          rf_raddr_o,
    input  logic [3*XLEN*LANES-1:0]      rf_rdata_i,
    input  logic [NUM_WB-1:0]            wb_valid_i,
    input  logic [5*NUM_WB-1:0]          wb_rd_i,
    input  logic [XLEN*NUM_WB-1:0]       wb_value_i,
    output logic [LANES-1:0]             op_valid_pre_o,
    output logic [LANES-1:0]             op_valid_o,
    output logic [3*LANES-1:0]           op_rs_valid_o,
    output logic [15*LANES-1:0]          op_rs_o,
    output logic [3*XLEN*LANES-1:0]      op_rs_value_o,
    output logic [PAYLOAD_W*LANES-1:0]   op_payload_o,
    output logic [SID_W*LANES-1:0]       op_sid_o
);
    logic [LANES-1:0]           valid_q, valid_d;
    logic [3*LANES-1:0]         rs_valid_q, rs_valid_d;
    logic [15*LANES-1:0]        rs_q, rs_d;
    logic [3*XLEN*LANES-1:0]    value_q, value_d;
    logic [PAYLOAD_W*LANES-1:0] payload_q, payload_d;
    logic [SID_W*LANES-1:0]     sid_q, sid_d;
`ifndef OPERAND_WB_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb_valid_i, wb_rd_i, wb_value_i};
`endif
    // Flush behaves as a hold that also drops valid, so held values keep snooping.
    always_comb begin
        valid_d    = valid_q;
        rs_valid_d = rs_valid_q;
        rs_d       = rs_q;
        value_d    = value_q;
        payload_d  = payload_q;
        sid_d      = sid_q;
        for (int l = 0; l < LANES; l++) begin
            if (stall_i[l] || flush_i[l]) begin
                valid_d[l] = valid_q[l] & ~flush_i[l];
`ifdef OPERAND_WB_BYPASS_EN
                for (int j = 0; j < 3; j++)
                    for (int w = 0; w < NUM_WB; w++)
                        if (wb_valid_i[w] && rs_q[(l*3+j)*5 +: 5] != 5'd0 && wb_rd_i[w*5 +: 5] == rs_q[(l*3+j)*5 +: 5])
                            value_d[(l*3+j)*XLEN +: XLEN] = wb_value_i[w*XLEN +: XLEN];
`endif
            end else begin
                valid_d[l]                       = dec_valid_i[l];
                rs_valid_d[l*3 +: 3]             = dec_rs_valid_i[l*3 +: 3];
                rs_d[l*15 +: 15]                 = dec_rs_i[l*15 +: 15];
                payload_d[l*PAYLOAD_W +: PAYLOAD_W] = dec_payload_i[l*PAYLOAD_W +: PAYLOAD_W];
                sid_d[l*SID_W +: SID_W]          = dec_sid_i[l*SID_W +: SID_W];
                for (int j = 0; j < 3; j++) begin
                    value_d[(l*3+j)*XLEN +: XLEN] = rf_rdata_i[(l*3+j)*XLEN +: XLEN];
`ifdef OPERAND_WB_BYPASS_EN
                    for (int w = 0; w < NUM_WB; w++)
                        if (wb_valid_i[w] && wb_rd_i[w*5 +: 5] == dec_rs_i[(l*3+j)*5 +: 5])
                            value_d[(l*3+j)*XLEN +: XLEN] = wb_value_i[w*XLEN +: XLEN];
`endif
                    if (dec_rs_i[(l*3+j)*5 +: 5] == 5'd0)
                        value_d[(l*3+j)*XLEN +: XLEN] = '0;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            rs_valid_q <= '0;
            rs_q       <= '0;
            value_q    <= '0;
            payload_q  <= '0;
            sid_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            rs_valid_q <= rs_valid_d;
            rs_q       <= rs_d;
            value_q    <= value_d;
            payload_q  <= payload_d;
            sid_q      <= sid_d;
        end
    end
    assign rf_raddr_o     = dec_rs_i;
    assign op_valid_pre_o = valid_q;
    assign op_valid_o     = valid_q & ~stall_i & ~flush_i;
    assign op_rs_valid_o  = rs_valid_q;
    assign op_rs_o        = rs_q;
    assign op_rs_value_o  = value_q;
    assign op_payload_o   = payload_q;
    assign op_sid_o       = sid_q;
endmodule

// File: tb/tb_operand_stage_n.sv
// tb_operand_stage_n: self-checking bench for operand_stage_n with LANES=4
module tb_operand_stage_n;
    localparam int L = 4, X = 64, W = 2, S = 5, P = 24;
    logic                 clk = 1'b0;
    logic                 rst;
    logic [L-1:0]         stall_i, flush_i, dec_valid_i;
    logic [3*L-1:0]       dec_rs_valid_i;
    logic [15*L-1:0]      dec_rs_i, rf_raddr_o;
    logic [P*L-1:0]       dec_payload_i, op_payload_o;
    logic [S*L-1:0]       dec_sid_i, op_sid_o;
    logic [3*X*L-1:0]     rf_rdata_i, op_rs_value_o;
    logic [W-1:0]         wb_valid_i;
    logic [5*W-1:0]       wb_rd_i;
    logic [X*W-1:0]       wb_value_i;
    logic [L-1:0]         op_valid_pre_o, op_valid_o;
    logic [3*L-1:0]       op_rs_valid_o;
    logic [15*L-1:0]      op_rs_o;
    always #5 clk = ~clk;
    operand_stage_n #(.LANES(L), .XLEN(X), .NUM_WB(W), .SID_W(S), .PAYLOAD_W(P)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .dec_valid_i(dec_valid_i), .dec_rs_valid_i(dec_rs_valid_i), .dec_rs_i(dec_rs_i),
        .dec_payload_i(dec_payload_i), .dec_sid_i(dec_sid_i), .rf_raddr_o(rf_raddr_o),
        .rf_rdata_i(rf_rdata_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_value_i(wb_value_i),
        .op_valid_pre_o(op_valid_pre_o), .op_valid_o(op_valid_o), .op_rs_valid_o(op_rs_valid_o),
        .op_rs_o(op_rs_o), .op_rs_value_o(op_rs_value_o), .op_payload_o(op_payload_o), .op_sid_o(op_sid_o)
    );
    typedef struct {string name; int kind; int lane; int j; logic [63:0] val;} exp_t;
    typedef struct {
        logic [4:0] idx; logic [63:0] rf;
        logic v0; logic [4:0] rd0; logic [63:0] d0;
        logic v1; logic [4:0] rd1; logic [63:0] d1;
        logic [63:0] e_byp; logic [63:0] e_raw;
    } vec_t;
    exp_t sb[$];
    vec_t tbl[6];
    int errors = 0, checks = 0;
    logic [4:0] held_sid;
    function automatic logic [63:0] pick(logic [63:0] byp, logic [63:0] raw);
`ifdef OPERAND_WB_BYPASS_EN
        return byp;
`else
        return raw;
`endif
    endfunction
    function automatic logic [63:0] get(int kind, int lane, int j);
        case (kind)
            0: return op_rs_value_o[(lane*3+j)*X +: X];
            1: return 64'(op_valid_pre_o[lane]);
            2: return 64'(op_sid_o[lane*S +: S]);
            3: return 64'(op_payload_o[lane*P +: P]);
            4: return 64'(op_rs_o[(lane*3+j)*5 +: 5]);
            default: return 64'(op_rs_valid_o[lane*3+j]);
        endcase
    endfunction
    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic expect_out(string n, int k, int l, int j, logic [63:0] v);
        sb.push_back('{n, k, l, j, v});
    endtask
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, get(e.kind, e.lane, e.j), e.val);
        end
    endtask
    task automatic set_rs(int l, int j, logic [4:0] idx, logic [63:0] rf);
        dec_rs_i[(l*3+j)*5 +: 5]   = idx;
        rf_rdata_i[(l*3+j)*X +: X] = rf;
        dec_rs_valid_i[l*3+j]      = 1'b1;
    endtask
    task automatic set_wb(int w, logic v, logic [4:0] rd, logic [63:0] d);
        wb_valid_i[w]          = v;
        wb_rd_i[w*5 +: 5]      = rd;
        wb_value_i[w*X +: X]   = d;
    endtask
    initial begin
        tbl[0] = '{5'd5,  64'h11,   1'b1, 5'd5, 64'hAA, 1'b1, 5'd5, 64'hBB, 64'hBB,   64'h11};
        tbl[1] = '{5'd5,  64'h11,   1'b1, 5'd5, 64'hAA, 1'b0, 5'd5, 64'hBB, 64'hAA,   64'h11};
        tbl[2] = '{5'd5,  64'h11,   1'b1, 5'd5, 64'hAA, 1'b1, 5'd6, 64'hBB, 64'hAA,   64'h11};
        tbl[3] = '{5'd0,  64'hFF,   1'b1, 5'd0, 64'h77, 1'b1, 5'd0, 64'h78, 64'h0,    64'h0};
        tbl[4] = '{5'd31, 64'h1234, 1'b0, 5'd31, 64'h9, 1'b0, 5'd0, 64'h0,  64'h1234, 64'h1234};
        tbl[5] = '{5'd9,  64'h3,    1'b0, 5'd9, 64'h44, 1'b1, 5'd10, 64'h45, 64'h3,   64'h3};
        rst = 1'b1; stall_i = '0; flush_i = '0; dec_valid_i = '1;
        dec_rs_valid_i = '1; dec_rs_i = {L{15'h1234}}; dec_payload_i = {L{24'hABCDEF}};
        dec_sid_i = {L{5'd7}}; rf_rdata_i = {(3*L){64'hDEAD}};
        wb_valid_i = '1; wb_rd_i = '0; wb_value_i = '1;
        step();
        step();
        check("rst_pre", 64'(op_valid_pre_o), 64'h0);
        check("rst_valid", 64'(op_valid_o), 64'h0);
        check("rst_value", 64'(|op_rs_value_o), 64'h0);
        check("rst_fields", 64'(|{op_rs_valid_o, op_rs_o, op_payload_o, op_sid_o}), 64'h0);
        rst = 1'b0; wb_valid_i = '0;
        for (int l = 0; l < L; l++) expect_out("post_rst_pre", 1, l, 0, 64'h1);
        step();
        check("post_rst_valid", 64'(op_valid_o), 64'hF);
        check("raddr", 64'(rf_raddr_o), 64'(dec_rs_i));
        for (int i = 0; i < 6; i++) begin
            set_rs(0, 0, tbl[i].idx, tbl[i].rf);
            set_wb(0, tbl[i].v0, tbl[i].rd0, tbl[i].d0);
            set_wb(1, tbl[i].v1, tbl[i].rd1, tbl[i].d1);
            expect_out($sformatf("cap%0d", i), 0, 0, 0, pick(tbl[i].e_byp, tbl[i].e_raw));
            expect_out($sformatf("cap_idx%0d", i), 4, 0, 0, 64'(tbl[i].idx));
            step();
        end
        wb_valid_i = '0;
        set_rs(1, 1, 5'd7, 64'h1);
        expect_out("snoop_cap", 0, 1, 1, 64'h1);
        step();
        stall_i[1] = 1'b1;
        set_rs(1, 1, 5'd8, 64'h99);
        expect_out("snoop_s1", 0, 1, 1, 64'h1);
        expect_out("snoop_s1_pre", 1, 1, 0, 64'h1);
        step();
        check("snoop_stall_valid", 64'(op_valid_o[1]), 64'h0);
        set_wb(0, 1'b1, 5'd7, 64'h55);
        set_wb(1, 1'b1, 5'd8, 64'h66);
        expect_out("snoop_s2", 0, 1, 1, pick(64'h55, 64'h1));
        step();
        wb_valid_i = '0;
        expect_out("snoop_s3", 0, 1, 1, pick(64'h55, 64'h1));
        expect_out("snoop_s3_idx", 4, 1, 1, 64'd7);
        expect_out("snoop_s3_pre", 1, 1, 0, 64'h1);
        step();
        stall_i[1] = 1'b0;
        set_rs(0, 2, 5'd0, 64'hFF);
        set_wb(0, 1'b1, 5'd0, 64'h77);
        expect_out("x0_cap", 0, 0, 2, 64'h0);
        step();
        stall_i[0] = 1'b1;
        expect_out("x0_hold", 0, 0, 2, 64'h0);
        step();
        stall_i[0] = 1'b0;
        wb_valid_i = '0;
        dec_payload_i[0*P +: P] = 24'h123456;
        dec_payload_i[1*P +: P] = 24'h0ABCDE;
        expect_out("fl_cap", 3, 0, 0, 64'h123456);
        step();
        stall_i[0] = 1'b1; flush_i[0] = 1'b1;
        dec_payload_i[0*P +: P] = 24'h654321;
        dec_payload_i[1*P +: P] = 24'h111111;
        #1;
        check("fl_valid_comb", 64'(op_valid_o[0]), 64'h0);
        expect_out("fl_pre0", 1, 0, 0, 64'h0);
        expect_out("fl_pay0", 3, 0, 0, 64'h123456);
        expect_out("fl_pay1", 3, 1, 0, 64'h111111);
        expect_out("fl_pre1", 1, 1, 0, 64'h1);
        step();
        stall_i = '0; flush_i = '0;
        held_sid = 5'd0;
        for (int c = 0; c < 4; c++) begin
            stall_i[2] = (c == 1 || c == 2);
            for (int l = 0; l < L; l++) dec_sid_i[l*S +: S] = 5'(c*4 + l + 1);
            if (!stall_i[2]) held_sid = 5'(c*4 + 3);
            for (int l = 0; l < L; l++)
                expect_out($sformatf("sid_c%0d_l%0d", c, l), 2, l, 0, (l == 2) ? 64'(held_sid) : 64'(c*4 + l + 1));
            step();
        end
        stall_i = '1; rst = 1'b1;
        step();
        check("rst_mid_pre", 64'(op_valid_pre_o), 64'h0);
        check("rst_mid_state", 64'(|{op_rs_value_o, op_sid_o, op_payload_o, op_rs_o}), 64'h0);
        rst = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
